// File: rtl/isp_pkg.sv
// Shared types and constants for the ISP line-buffer scheduler.
// Holds the state encoding and the geometry of the four-line ring.
package isp_pkg;

    localparam int NUM_LINES = 4;
    localparam int SEL_W     = $clog2(NUM_LINES);
    localparam int FILL_W    = $clog2(NUM_LINES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/isp_line_ring_cnt.sv
// Ring pointers plus occupancy counter for the line buffers.
// The caller only raises i_inc when not full and i_dec when not empty.
module isp_line_ring_cnt
    import isp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic [SEL_W-1:0]  o_wr_ptr,
    output logic [SEL_W-1:0]  o_rd_ptr,
    output logic [FILL_W-1:0] o_fill,
    output logic              o_full,
    output logic              o_empty
);

    logic [SEL_W-1:0]  r_wr_ptr;
    logic [SEL_W-1:0]  r_rd_ptr;
    logic [FILL_W-1:0] r_fill;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (i_inc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_dec) r_rd_ptr <= r_rd_ptr + 1'b1;
            // A simultaneous fill and drain leaves the occupancy unchanged.
            case ({i_inc, i_dec})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_fill   = r_fill;
    assign o_full   = (r_fill == FILL_W'(NUM_LINES));
    assign o_empty  = (r_fill == '0);

endmodule

// File: rtl/isp_line_sched.sv
// Line-buffer scheduler between the raw writer and the demosaic reader:
// frame sequencing, read-start pacing, rgb_valid gating and error flags.
module isp_line_sched
    import isp_pkg::*;
#(
    parameter int PRIME_LINES = 2,
    parameter int FRAME_LINES = 480,
    parameter int CNT_WIDTH   = $clog2(FRAME_LINES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 frame_start,
    input  logic                 wr_line_done,
    input  logic                 rd_line_done,
    output logic [SEL_W-1:0]     wr_line_sel,
    output logic [SEL_W-1:0]     rd_line_sel,
    output logic                 rd_start,
    output logic                 rgb_valid,
    output logic [FILL_W-1:0]    fill_level,
    output logic [CNT_WIDTH-1:0] rd_line_cnt,
    output logic                 frame_done,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [CNT_WIDTH-1:0] FRAME_CNT    = CNT_WIDTH'(FRAME_LINES);
    localparam logic [CNT_WIDTH-1:0] FRAME_CNT_M1 = CNT_WIDTH'(FRAME_LINES - 1);
    localparam logic [FILL_W-1:0]    PRIME_FILL   = FILL_W'(PRIME_LINES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_wr_cnt;
    logic [CNT_WIDTH-1:0] r_rd_cnt;
    logic [CNT_WIDTH-1:0] w_wr_cnt_nxt;
    logic                 r_rd_busy;
    logic                 r_rd_start;
    logic                 r_rgb_valid;
    logic                 r_frame_done;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_clr;
    logic                 w_active;
    logic                 w_wr_req;
    logic                 w_wr_ok;
    logic                 w_wr_drop;
    logic                 w_rd_ok;
    logic                 w_rd_under;
    logic                 w_last_rd;
    logic                 w_rd_cond;
    logic                 w_rd_issue;
    logic                 w_full;
    logic                 w_empty;
    logic [FILL_W-1:0]    w_fill;

    // Line pulses only count inside an active frame; a restart or disable
    // in the same cycle discards them.
    assign w_clr        = !enable || frame_start;
    assign w_active     = enable && !frame_start && (r_state != IDLE);
    assign w_wr_req     = w_active && wr_line_done && (r_wr_cnt != FRAME_CNT);
    assign w_wr_ok      = w_wr_req && !w_full;
    assign w_wr_drop    = w_wr_req && w_full;
    assign w_rd_ok      = w_active && rd_line_done && !w_empty;
    assign w_rd_under   = w_active && rd_line_done && w_empty;
    assign w_wr_cnt_nxt = r_wr_cnt + CNT_WIDTH'(w_wr_ok);
    assign w_last_rd    = (r_state == DRAIN) && w_rd_ok && (r_rd_cnt == FRAME_CNT_M1);

    isp_line_ring_cnt u_ring (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_inc    (w_wr_ok),
        .i_dec    (w_rd_ok),
        .o_wr_ptr (wr_line_sel),
        .o_rd_ptr (rd_line_sel),
        .o_fill   (w_fill),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else if (frame_start) begin
            w_state_nxt = PRIME;
        end else begin
            case (r_state)
                PRIME:   if (w_fill >= PRIME_FILL)      w_state_nxt = RUN;
                RUN:     if (w_wr_cnt_nxt == FRAME_CNT) w_state_nxt = DRAIN;
                DRAIN:   if (w_last_rd)                 w_state_nxt = IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Read pacing is judged against the state being entered, so the first
    // start of a frame coincides with rgb_valid rising.
    always_comb begin
        w_rd_cond = 1'b0;
        if (w_state_nxt == RUN)        w_rd_cond = (w_fill >= PRIME_FILL);
        else if (w_state_nxt == DRAIN) w_rd_cond = (w_fill != '0);
    end

    assign w_rd_issue = w_rd_cond && !r_rd_busy && !w_rd_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_rd_busy    <= 1'b0;
            r_rd_start   <= 1'b0;
            r_rgb_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rgb_valid  <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
            r_rd_start   <= w_rd_issue;
            r_frame_done <= w_last_rd;
            if (w_wr_drop)  r_overflow  <= 1'b1;
            if (w_rd_under) r_underflow <= 1'b1;
            if (w_clr) begin
                r_wr_cnt  <= '0;
                r_rd_cnt  <= '0;
                r_rd_busy <= 1'b0;
            end else begin
                r_wr_cnt <= w_wr_cnt_nxt;
                if (w_rd_ok) begin
                    r_rd_cnt  <= r_rd_cnt + 1'b1;
                    r_rd_busy <= 1'b0;
                end else if (w_rd_issue) begin
                    r_rd_busy <= 1'b1;
                end
            end
        end
    end

    assign rd_start    = r_rd_start;
    assign rgb_valid   = r_rgb_valid;
    assign fill_level  = w_fill;
    assign rd_line_cnt = r_rd_cnt;
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_isp_line_sched.sv
// Bench for isp_line_sched: a count-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_isp_line_sched;

    localparam int FL = 8;
    localparam int PL = 2;
    localparam int CW = $clog2(FL + 1);
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          frame_start = 1'b0;
    logic          wr_line_done = 1'b0;
    logic          rd_line_done = 1'b0;
    logic [1:0]    wr_line_sel;
    logic [1:0]    rd_line_sel;
    logic          rd_start;
    logic          rgb_valid;
    logic [2:0]    fill_level;
    logic [CW-1:0] rd_line_cnt;
    logic          frame_done;
    logic          overflow;
    logic          underflow;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: frame phase plus accepted write/read counts; fill and the
    // ring selects are derived from the counts.
    int m_st = M_IDLE;
    int m_wr = 0;
    int m_rd = 0;
    bit m_busy = 1'b0;
    bit m_ov = 1'b0;
    bit m_un = 1'b0;
    bit e_start = 1'b0;
    bit e_done = 1'b0;

    isp_line_sched #(
        .PRIME_LINES (PL),
        .FRAME_LINES (FL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .frame_start  (frame_start),
        .wr_line_done (wr_line_done),
        .rd_line_done (rd_line_done),
        .wr_line_sel  (wr_line_sel),
        .rd_line_sel  (rd_line_sel),
        .rd_start     (rd_start),
        .rgb_valid    (rgb_valid),
        .fill_level   (fill_level),
        .rd_line_cnt  (rd_line_cnt),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: dut=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int fill;
        int nst;
        bit wr_ok;
        bit rd_ok;
        e_start = 1'b0;
        e_done  = 1'b0;
        if (rst) begin
            m_st = M_IDLE; m_wr = 0; m_rd = 0; m_busy = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else if (!enable) begin
            m_st = M_IDLE; m_wr = 0; m_rd = 0; m_busy = 1'b0;
        end else if (frame_start) begin
            m_st = M_PRIME; m_wr = 0; m_rd = 0; m_busy = 1'b0;
        end else if (m_st != M_IDLE) begin
            fill  = m_wr - m_rd;
            wr_ok = wr_line_done && (m_wr < FL) && (fill < 4);
            if (wr_line_done && (m_wr < FL) && (fill == 4)) m_ov = 1'b1;
            rd_ok = rd_line_done && (fill > 0);
            if (rd_line_done && (fill == 0)) m_un = 1'b1;
            nst = m_st;
            if (m_st == M_PRIME && fill >= PL) nst = M_RUN;
            else if (m_st == M_RUN && m_wr + int'(wr_ok) == FL) nst = M_DRAIN;
            else if (m_st == M_DRAIN && rd_ok && m_rd + 1 == FL) begin
                nst = M_IDLE;
                e_done = 1'b1;
            end
            if (rd_ok) m_busy = 1'b0;
            else if (!m_busy && ((nst == M_RUN && fill >= PL) || (nst == M_DRAIN && fill >= 1))) begin
                e_start = 1'b1;
                m_busy  = 1'b1;
            end
            m_wr += int'(wr_ok);
            m_rd += int'(rd_ok);
            m_st = nst;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fill_level",  32'(fill_level),  m_wr - m_rd);
            chk("wr_line_sel", 32'(wr_line_sel), m_wr % 4);
            chk("rd_line_sel", 32'(rd_line_sel), m_rd % 4);
            chk("rd_line_cnt", 32'(rd_line_cnt), m_rd);
            chk("rd_start",    32'(rd_start),    32'(e_start));
            chk("frame_done",  32'(frame_done),  32'(e_done));
            chk("rgb_valid",   32'(rgb_valid),   32'(m_st == M_RUN || m_st == M_DRAIN));
            chk("overflow",    32'(overflow),    32'(m_ov));
            chk("underflow",   32'(underflow),   32'(m_un));
        end
    end

    task automatic step(input bit en, input bit fs, input bit wr, input bit rd);
        enable       = en;
        frame_start  = fs;
        wr_line_done = wr;
        rd_line_done = rd;
        @(posedge clk);
        #2;
    endtask

    initial begin : driver
        bit found;
        bit s_en;
        bit s_fs;
        bit s_wr;
        bit s_rd;
        int frames;

        rst = 1'b1;
        repeat (3) step(0, 0, 0, 0);
        chk_en = 1'b1;
        chk("lit_reset_fill", 32'(fill_level), 0);
        chk("lit_reset_rgb",  32'(rgb_valid), 0);
        chk("lit_reset_ov",   32'(overflow), 0);
        rst = 1'b0;

        // Nominal frame: prime with two lines, then stream to completion.
        step(1, 1, 0, 0);
        $display("txn frame_start: fill=%0d rgb_valid=%0d", fill_level, rgb_valid);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        $display("txn two writes: fill=%0d", fill_level);
        chk("lit_prime_fill",     32'(fill_level), 2);
        chk("lit_prime_rgb",      32'(rgb_valid), 0);
        chk("lit_prime_rd_start", 32'(rd_start), 0);
        step(1, 0, 0, 0);
        $display("txn enter run: rgb_valid=%0d rd_start=%0d", rgb_valid, rd_start);
        chk("lit_run_rgb",      32'(rgb_valid), 1);
        chk("lit_run_rd_start", 32'(rd_start), 1);
        step(1, 0, 0, 0);
        chk("lit_busy_no_start", 32'(rd_start), 0);

        step(1, 0, 1, 1);
        $display("txn simultaneous: fill=%0d wr_sel=%0d rd_sel=%0d", fill_level, wr_line_sel, rd_line_sel);
        chk("lit_sim_fill",   32'(fill_level), 2);
        chk("lit_sim_wr_sel", 32'(wr_line_sel), 3);
        chk("lit_sim_rd_sel", 32'(rd_line_sel), 1);
        chk("lit_sim_rd_cnt", 32'(rd_line_cnt), 1);
        step(1, 0, 0, 0);
        chk("lit_restart_read", 32'(rd_start), 1);

        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            step(1, 0, (c % 2 == 0), m_busy);
            if (frame_done) begin
                found = 1'b1;
                $display("txn frame_done: rd_line_cnt=%0d", rd_line_cnt);
                chk("lit_done_rd_cnt", 32'(rd_line_cnt), FL);
                chk("lit_done_rgb",    32'(rgb_valid), 0);
                chk("lit_done_wr_sel", 32'(wr_line_sel), 0);
            end
        end
        chk("lit_frame_done_seen", 32'(found), 1);
        step(1, 0, 0, 0);
        chk("lit_done_one_cycle", 32'(frame_done), 0);
        chk("lit_no_ov_yet",      32'(overflow), 0);

        // Overflow: five writes, no reads.
        step(1, 1, 0, 0);
        repeat (5) step(1, 0, 1, 0);
        $display("txn overflow: fill=%0d ov=%0d wr_sel=%0d", fill_level, overflow, wr_line_sel);
        chk("lit_ov_fill",   32'(fill_level), 4);
        chk("lit_ov_flag",   32'(overflow), 1);
        chk("lit_ov_wr_sel", 32'(wr_line_sel), 0);

        // Restart mid-RUN, then underflow in PRIME.
        step(1, 1, 0, 0);
        $display("txn restart: fill=%0d rgb_valid=%0d", fill_level, rgb_valid);
        chk("lit_rs_fill",   32'(fill_level), 0);
        chk("lit_rs_wr_sel", 32'(wr_line_sel), 0);
        chk("lit_rs_rgb",    32'(rgb_valid), 0);
        step(1, 0, 0, 1);
        $display("txn underflow: un=%0d rd_cnt=%0d", underflow, rd_line_cnt);
        chk("lit_un_flag",   32'(underflow), 1);
        chk("lit_un_rd_cnt", 32'(rd_line_cnt), 0);
        chk("lit_un_rd_sel", 32'(rd_line_sel), 0);

        // Disable mid-frame keeps the sticky flags.
        repeat (3) step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        $display("txn disable: rgb_valid=%0d fill=%0d ov=%0d un=%0d", rgb_valid, fill_level, overflow, underflow);
        chk("lit_dis_rgb",  32'(rgb_valid), 0);
        chk("lit_dis_fill", 32'(fill_level), 0);
        chk("lit_dis_ov",   32'(overflow), 1);
        chk("lit_dis_un",   32'(underflow), 1);

        rst = 1'b1;
        repeat (2) step(0, 0, 0, 0);
        rst = 1'b0;
        chk("lit_rst_clears_ov", 32'(overflow), 0);

        // Randomized traffic against the model.
        frames = 0;
        for (int c = 0; c < 4000; c++) begin
            s_en = ($urandom_range(0, 299) != 0);
            s_fs = (m_st == M_IDLE) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 399) == 0);
            s_wr = ($urandom_range(0, 2) == 0);
            s_rd = m_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
            step(s_en, s_fs, s_wr, s_rd);
            if (frame_done) begin
                frames++;
                $display("txn random frame %0d done at cycle %0d", frames, c);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
